// File: rtl/calc_controller.sv
// Two-operand digit calculator front end: synchronised buttons, ALU handshake, result latch.
// Optional ALU-timeout/ERROR state is enabled by defining CALC_TIMEOUT_EN.
module calc_controller (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Button1,
    input  logic       Button2,
    input  logic       Operation,
    input  logic       Equals,
    input  logic       AluDone,
    input  logic [7:0] AluResult,
    output logic [3:0] OpA,
    output logic [3:0] OpB,
    output logic       AluOp,
    output logic       AluStart,
    output logic [7:0] Result,
    output logic       ShowResult,
    output logic       Busy
`ifdef CALC_TIMEOUT_EN
    ,
    output logic       Error
`endif
);

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        WAIT_ALU = 2'd1,
        RESULT   = 2'd2,
        ERROR    = 2'd3
    } state_t;

    state_t state;

    // Bit order: [0]=Button1 [1]=Button2 [2]=Operation [3]=Equals
    logic [3:0] raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] hist;
    logic [3:0] ev;

    assign raw = {Equals, Operation, Button2, Button1};

    // Event is registered once more so it lands on the third edge after sampling
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1 <= 4'b0;
            sync2 <= 4'b0;
            hist  <= 4'b0;
            ev    <= 4'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            hist  <= sync2;
            ev    <= sync2 & ~hist;
        end
    end

    function automatic logic [3:0] inc_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

`ifdef CALC_TIMEOUT_EN
    logic [4:0] wait_cnt;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= ENTRY;
            OpA        <= 4'd0;
            OpB        <= 4'd0;
            AluOp      <= 1'b0;
            AluStart   <= 1'b0;
            Result     <= 8'd0;
            ShowResult <= 1'b0;
            Busy       <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            Error      <= 1'b0;
            wait_cnt   <= 5'd0;
`endif
        end else begin
            AluStart <= 1'b0;
            case (state)
                ENTRY: begin
                    if (ev[3]) begin
                        AluStart <= 1'b1;
                        Busy     <= 1'b1;
                        state    <= WAIT_ALU;
`ifdef CALC_TIMEOUT_EN
                        wait_cnt <= 5'd0;
`endif
                    end else begin
                        if (ev[0]) OpA <= inc_digit(OpA);
                        if (ev[1]) OpB <= inc_digit(OpB);
                        if (ev[2]) AluOp <= ~AluOp;
                    end
                end
                WAIT_ALU: begin
                    if (AluDone) begin
                        Result     <= AluResult;
                        Busy       <= 1'b0;
                        ShowResult <= 1'b1;
                        state      <= RESULT;
`ifdef CALC_TIMEOUT_EN
                    end else if (wait_cnt == 5'd15) begin
                        Busy  <= 1'b0;
                        Error <= 1'b1;
                        state <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 5'd1;
`endif
                    end
                end
                RESULT: begin
                    if (ev[3]) begin
                        AluStart   <= 1'b1;
                        Busy       <= 1'b1;
                        ShowResult <= 1'b0;
                        state      <= WAIT_ALU;
`ifdef CALC_TIMEOUT_EN
                        wait_cnt   <= 5'd0;
`endif
                    end else if (|ev[2:0]) begin
                        ShowResult <= 1'b0;
                        state      <= ENTRY;
                    end
                end
`ifdef CALC_TIMEOUT_EN
                ERROR: begin
                    if (|ev) begin
                        Error <= 1'b0;
                        state <= ENTRY;
                    end
                end
`endif
                default: state <= ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller: vector table, corner sequences, random vs model.
// Timeout checks are compiled in when CALC_TIMEOUT_EN is defined.
module tb_calc_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Button1 = 1'b0;
    logic       Button2 = 1'b0;
    logic       Operation = 1'b0;
    logic       Equals = 1'b0;
    logic       AluDone = 1'b0;
    logic [7:0] AluResult = 8'd0;
    logic [3:0] OpA;
    logic [3:0] OpB;
    logic       AluOp;
    logic       AluStart;
    logic [7:0] Result;
    logic       ShowResult;
    logic       Busy;
`ifdef CALC_TIMEOUT_EN
    logic       Error;
`endif

    calc_controller dut (
        .Clock(Clock),
        .Reset(Reset),
        .Button1(Button1),
        .Button2(Button2),
        .Operation(Operation),
        .Equals(Equals),
        .AluDone(AluDone),
        .AluResult(AluResult),
        .OpA(OpA),
        .OpB(OpB),
        .AluOp(AluOp),
        .AluStart(AluStart),
        .Result(Result),
        .ShowResult(ShowResult),
        .Busy(Busy)
`ifdef CALC_TIMEOUT_EN
        ,
        .Error(Error)
`endif
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;

    // Model: 0=entry 1=waiting 2=showing result 3=error
    int m_state = 0;
    int m_a = 0;
    int m_b = 0;
    int m_op = 0;
    int m_res = 0;
    int m_starts = 0;
    int m_start_snap = 0;

    int start_cnt = 0;
    int start_snap = 0;
    int double_start = 0;
    logic prev_start = 1'b0;

    always @(negedge Clock) begin
        if (AluStart) begin
            start_cnt++;
            start_snap = int'({AluOp, OpA, OpB});
            if (prev_start) double_start++;
        end
        prev_start = AluStart;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_start();
        m_state = 1;
        m_starts++;
        m_start_snap = m_op * 256 + m_a * 16 + m_b;
    endtask

    task automatic model_press(input int mask);
        case (m_state)
            0: begin
                if (mask[3]) model_start();
                else begin
                    if (mask[0]) m_a = (m_a + 1) % 10;
                    if (mask[1]) m_b = (m_b + 1) % 10;
                    if (mask[2]) m_op = 1 - m_op;
                end
            end
            2: begin
                if (mask[3]) model_start();
                else if ((mask & 7) != 0) m_state = 0;
            end
            3: if (mask != 0) m_state = 0;
            default: ;
        endcase
    endtask

    task automatic model_done(input int v);
        if (m_state == 1) begin
            m_res = v;
            m_state = 2;
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_a = 0;
        m_b = 0;
        m_op = 0;
        m_res = 0;
    endtask

    task automatic press(input int mask);
        @(negedge Clock);
        {Equals, Operation, Button2, Button1} = mask[3:0];
        repeat (3) @(negedge Clock);
        {Equals, Operation, Button2, Button1} = 4'b0;
        repeat (6) @(negedge Clock);
        model_press(mask);
    endtask

    task automatic alu_done(input int v);
        @(negedge Clock);
        AluDone = 1'b1;
        AluResult = v[7:0];
        @(negedge Clock);
        AluDone = 1'b0;
        AluResult = 8'd0;
        @(negedge Clock);
        model_done(v);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".OpA"}, int'(OpA), m_a);
        chk({tag, ".OpB"}, int'(OpB), m_b);
        chk({tag, ".AluOp"}, int'(AluOp), m_op);
        chk({tag, ".Busy"}, int'(Busy), int'(m_state == 1));
        chk({tag, ".ShowResult"}, int'(ShowResult), int'(m_state == 2));
        chk({tag, ".Result"}, int'(Result), m_res);
        chk({tag, ".starts"}, start_cnt, m_starts);
`ifdef CALC_TIMEOUT_EN
        chk({tag, ".Error"}, int'(Error), int'(m_state == 3));
`endif
    endtask

    typedef struct {
        int act;
        int data;
        int a;
        int b;
        int op;
        int busy;
        int show;
        int res;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(int act, int data, int a, int b, int op,
                                int busy, int show, int res);
        vec_t v;
        v.act = act;
        v.data = data;
        v.a = a;
        v.b = b;
        v.op = op;
        v.busy = busy;
        v.show = show;
        v.res = res;
        return v;
    endfunction

    localparam int DONE = 16;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 10 Button1 presses: 1..9 then wrap to 0
        for (int i = 1; i <= 10; i++) tv.push_back(mk(1, 0, i % 10, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 3; i++) tv.push_back(mk(1, 0, i, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++) tv.push_back(mk(2, 0, 3, i, 0, 0, 0, 0));
        tv.push_back(mk(8, 0, 3, 5, 0, 1, 0, 0));
        tv.push_back(mk(DONE, 8, 3, 5, 0, 0, 1, 8));
        // Leaving RESULT discards the button that caused it
        tv.push_back(mk(1, 0, 3, 5, 0, 0, 0, 8));
        for (int i = 1; i <= 9; i++) tv.push_back(mk(1, 0, (3 + i) % 10, 5, 0, 0, 0, 8));
        tv.push_back(mk(2, 0, 2, 6, 0, 0, 0, 8));
        tv.push_back(mk(2, 0, 2, 7, 0, 0, 0, 8));
        tv.push_back(mk(4, 0, 2, 7, 1, 0, 0, 8));
        tv.push_back(mk(8, 0, 2, 7, 1, 1, 0, 8));
        tv.push_back(mk(DONE, 'hFB, 2, 7, 1, 0, 1, 'hFB));
        tv.push_back(mk(8, 0, 2, 7, 1, 1, 0, 'hFB));
        tv.push_back(mk(DONE, 'h05, 2, 7, 1, 0, 1, 'h05));
        tv.push_back(mk(2, 0, 2, 7, 1, 0, 0, 'h05));
        tv.push_back(mk(1, 0, 3, 7, 1, 0, 0, 'h05));
        tv.push_back(mk(1, 0, 4, 7, 1, 0, 0, 'h05));
        // Equals with Button1 in the same cycle: start wins, OpA stays 4
        tv.push_back(mk(9, 0, 4, 7, 1, 1, 0, 'h05));
        tv.push_back(mk(DONE, 'h44, 4, 7, 1, 0, 1, 'h44));
        tv.push_back(mk(1, 0, 4, 7, 1, 0, 0, 'h44));
        // AluDone outside WAIT_ALU is ignored
        tv.push_back(mk(DONE, 'h99, 4, 7, 1, 0, 0, 'h44));
        tv.push_back(mk(7, 0, 5, 8, 0, 0, 0, 'h44));

        repeat (3) @(negedge Clock);
        chk("reset.OpA", int'(OpA), 0);
        chk("reset.Busy", int'(Busy), 0);
        chk("reset.Result", int'(Result), 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        check_all("reset");

        for (int i = 0; i < tv.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (tv[i].act == DONE) alu_done(tv[i].data);
            else press(tv[i].act);
            chk({nm, ".OpA"}, int'(OpA), tv[i].a);
            chk({nm, ".OpB"}, int'(OpB), tv[i].b);
            chk({nm, ".AluOp"}, int'(AluOp), tv[i].op);
            chk({nm, ".Busy"}, int'(Busy), tv[i].busy);
            chk({nm, ".ShowResult"}, int'(ShowResult), tv[i].show);
            chk({nm, ".Result"}, int'(Result), tv[i].res);
            chk({nm, ".starts"}, start_cnt, m_starts);
            if (tv[i].act == DONE && tv[i].show == 1)
                chk({nm, ".start_ops"}, start_snap, m_start_snap);
        end

        // Event latency: applied on the third edge after the sampling edge
        @(negedge Clock);
        Button1 = 1'b1;
        @(posedge Clock);
        @(posedge Clock);
        #1 chk("latency.e1", int'(OpA), m_a);
        @(posedge Clock);
        #1 chk("latency.e2", int'(OpA), m_a);
        @(posedge Clock);
        #1 chk("latency.e3", int'(OpA), (m_a + 1) % 10);
        @(negedge Clock);
        Button1 = 1'b0;
        repeat (6) @(negedge Clock);
        model_press(1);
        check_all("latency");

        // Reset while waiting for the ALU abandons the operation
        press(8);
        check_all("rst_wait.pre");
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        model_reset();
        @(negedge Clock);
        AluDone = 1'b1;
        AluResult = 8'h77;
        @(negedge Clock);
        AluDone = 1'b0;
        AluResult = 8'd0;
        repeat (2) @(negedge Clock);
        chk("rst_wait.AluStart", int'(AluStart), 0);
        check_all("rst_wait");
        press(1);
        check_all("rst_wait.entry");

        // Button held through reset release yields exactly one event
        @(negedge Clock);
        Reset = 1'b1;
        Button1 = 1'b1;
        model_reset();
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (8) @(negedge Clock);
        Button1 = 1'b0;
        repeat (6) @(negedge Clock);
        model_press(1);
        check_all("held_reset");

`ifdef CALC_TIMEOUT_EN
        press(2);
        press(8);
        repeat (20) @(negedge Clock);
        m_state = 3;
        chk("timeout.Error", int'(Error), 1);
        chk("timeout.Busy", int'(Busy), 0);
        press(2);
        chk("timeout.clear", int'(Error), 0);
        check_all("timeout.exit");
        press(2);
        check_all("timeout.entry");
`endif

        for (int i = 0; i < 200; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
`ifdef CALC_TIMEOUT_EN
            if (m_state == 1) r = 99;
`endif
            if (r >= 80) alu_done(int'($urandom_range(0, 255)));
            else if (r < 70) press(1 << $urandom_range(0, 3));
            else press(int'($urandom_range(1, 15)));
            check_all($sformatf("rand%0d", i));
        end

        chk("start_pulse_width", double_start, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_controller.md
CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 SHALL have port Clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Button1, input, 1 bit: raw operand-A increment button, asynchronous to Clock.
REQ-004 SHALL have port Button2, input, 1 bit: raw operand-B increment button, asynchronous to Clock.
REQ-005 SHALL have port Operation, input, 1 bit: raw add/subtract toggle button.
REQ-006 SHALL have port Equals, input, 1 bit: raw compute button.
REQ-007 SHALL have port AluDone, input, 1 bit: ALU completion strobe, one cycle.
REQ-008 SHALL have port AluResult, input, 8 bits: ALU result, two's complement, valid while AluDone=1.
REQ-009 SHALL have port OpA, output, 4 bits: operand A to ALU, range 0-9.
REQ-010 SHALL have port OpB, output, 4 bits: operand B to ALU, range 0-9.
REQ-011 SHALL have port AluOp, output, 1 bit: 0=add, 1=subtract.
REQ-012 SHALL have port AluStart, output, 1 bit: one-cycle ALU start pulse.
REQ-013 SHALL have port Result, output, 8 bits: latched ALU result.
REQ-014 SHALL have port ShowResult, output, 1 bit: 1 selects Result for the display, 0 selects operands.
REQ-015 SHALL have port Busy, output, 1 bit: 1 while waiting for the ALU.

Function
REQ-016 SHALL pass each button through a 2-flop synchronizer plus a history flop; event = sync2 & ~history, so each press gives exactly one event.
REQ-017 SHALL apply an event at the 3rd rising Clock edge after the edge that first samples the button high.
REQ-018 SHALL implement FSM states ENTRY, WAIT_ALU and RESULT.
REQ-019 SHALL, in ENTRY on a Button1 event, set OpA to OpA+1, wrapping 9 to 0; Button2 does the same for OpB.
REQ-020 SHALL, in ENTRY, toggle AluOp on each Operation event.
REQ-021 SHALL, in ENTRY on an Equals event, assert AluStart for exactly one cycle and move to WAIT_ALU.
REQ-022 SHALL give the Equals event priority over same-cycle Button1, Button2 and Operation events, which are discarded.
REQ-023 SHALL apply Button1, Button2 and Operation events in the same cycle together when no Equals event is present.
REQ-024 SHALL, in WAIT_ALU, hold Busy=1 and ignore all button events.
REQ-025 SHALL, in WAIT_ALU on AluDone=1, latch AluResult into Result and go to RESULT at that same edge.
REQ-026 SHALL, in RESULT, hold ShowResult=1.
REQ-027 SHALL, in RESULT, return to ENTRY on any Button1, Button2 or Operation event, without applying that event; operands and AluOp are kept.
REQ-028 SHALL, in RESULT on an Equals event, reissue AluStart with the current operands and go to WAIT_ALU.
REQ-029 SHALL ignore AluDone in every state other than WAIT_ALU.
REQ-030 SHALL hold OpA, OpB and AluOp stable from the AluStart cycle until AluDone.

Reset
REQ-031 SHALL, on Reset, set state to ENTRY, OpA=0, OpB=0, AluOp=0, AluStart=0, Result=0, ShowResult=0, Busy=0, and all synchronizer and history flops to 0.
REQ-032 SHALL, on Reset asserted in WAIT_ALU, abandon the operation; a later AluDone does not update Result.
REQ-033 SHALL treat a button held high through reset release as generating one event.

Configuration
REQ-034 SHALL, with CALC_TIMEOUT_EN defined, add state ERROR, output Error (1 bit, reset 0) and a 5-bit wait counter.
REQ-035 SHALL, with CALC_TIMEOUT_EN defined, go from WAIT_ALU to ERROR with Error=1 and Busy=0 after 16 cycles without AluDone.
REQ-036 SHALL, with CALC_TIMEOUT_EN defined, leave ERROR for ENTRY on any button event, clearing Error.
REQ-037 SHALL, without CALC_TIMEOUT_EN, have no Error port and no counter, and wait in WAIT_ALU indefinitely.

Verification
REQ-038 Bench SHALL cover: 10 Button1 presses from reset -> OpA steps 1..9 then 0; OpB stays 0.
REQ-039 Bench SHALL cover: OpA=3, OpB=5, Equals -> one AluStart pulse, Busy=1; AluDone with AluResult=8 -> Result=8, ShowResult=1, Busy=0.
REQ-040 Bench SHALL cover: Operation press then Equals with OpA=2, OpB=7 -> AluOp=1 at AluStart; AluResult=0xFB latched as Result=0xFB.
REQ-041 Bench SHALL cover: Equals and Button1 in the same cycle with OpA=4 -> AluStart asserted and OpA stays 4.
REQ-042 Bench SHALL cover: Reset asserted in WAIT_ALU, then AluDone=1 -> all outputs 0 and state ENTRY.
REQ-043 Bench SHALL cover, with CALC_TIMEOUT_EN: no AluDone for 16 cycles -> Error=1; then a Button2 press -> Error=0, ENTRY, OpB unchanged.
